// File: rtl/camara_pkg.sv
// Shared definitions for the disinfection chamber: state codes, keypad codes, width helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package camara_pkg;

  // State codes are exported on `estado` and decoded by the LCD message logic.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRADA = 3'd1,
    ST_DESINF  = 3'd2,
    ST_SALIDA  = 3'd3,
    ST_ABORTO  = 3'd4
  } estado_t;

  // Keypad codes shared with the keypad scanner and the LCD block.
  localparam logic [5:0] KEY_INICIO = 6'd1;
  localparam logic [5:0] KEY_ABORTO = 6'd10;
  localparam logic [5:0] KEY_REARME = 6'd11;

  // Number of bits needed to hold `valor` (at least 1).
  function automatic int bits_para(input int valor);
    if (valor <= 1) return 1;
    return $clog2(valor + 1);
  endfunction

endpackage

// File: rtl/antirrebote_sensor.sv
// FC-51 input conditioning: 2-FF synchronizer, free-running ms tick, tick-based debounce.
// Latency: 2 sync cycles + DEBOUNCE_MS ticks to accept a level; pres_rise is registered with the level.
// Backpressure: none; pres_rise and tick_ms are single-cycle pulses that are not held.
// Ports: clk/rst_n clock and async active-low reset; sensor raw async presence input;
//        nivel debounced level; pres_rise pulse on debounced 0->1; tick_ms 1-cycle ms tick.
module antirrebote_sensor
  import camara_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor,
  output logic nivel,
  output logic pres_rise,
  output logic tick_ms
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int DW  = bits_para(DIV - 1);
  localparam int CW  = bits_para(DEBOUNCE_MS);

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] deb_cnt;
  logic          s_meta;
  logic          s_sync;

  // Tick is decoded from the divider so it is available to the FSM in the same cycle.
  assign tick_ms = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick_ms) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
    end else begin
      s_meta <= sensor;
      s_sync <= s_meta;
    end
  end

  // Count ticks while the synchronized input disagrees with the accepted level;
  // any return to agreement (a bounce) restarts the count from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt   <= '0;
      nivel     <= 1'b0;
      pres_rise <= 1'b0;
    end else begin
      pres_rise <= 1'b0;
      if (s_sync == nivel) begin
        deb_cnt <= '0;
      end else if (tick_ms) begin
        if (deb_cnt == CW'(DEBOUNCE_MS - 1)) begin
          nivel     <= s_sync;
          pres_rise <= s_sync;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/secuenciador_camara.sv
// Disinfection cycle sequencer: entry door, spray/UV, exit door, with keypad abort/re-arm.
// Latency: state changes 1 cycle after the triggering event; outputs follow the state 1 cycle later.
// Backpressure: none; ignored keys and presence edges are dropped, never queued.
// Ports: CLOCK_50/rst_n clock and async active-low reset; sensor raw presence; tecla/tecla_stb keypad;
//        zumbador/led/servo180/servo360 actuator commands; estado state code; ciclos saturating
//        completed-cycle count; fin_pulso 1-cycle pulse on normal completion.
module secuenciador_camara
  import camara_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int DEBOUNCE_MS  = 20,
  parameter int T_ENTRADA_MS = 3000,
  parameter int T_DESINF_MS  = 10000,
  parameter int T_SALIDA_MS  = 3000,
  parameter int BEEP_MS      = 500
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       sensor,
  input  logic [5:0] tecla,
  input  logic       tecla_stb,
  output logic       zumbador,
  output logic       led,
  output logic       servo180,
  output logic       servo360,
  output logic [2:0] estado,
  output logic [7:0] ciclos,
  output logic       fin_pulso
);

  localparam int T_MAX0 = (T_ENTRADA_MS > T_SALIDA_MS) ? T_ENTRADA_MS : T_SALIDA_MS;
  localparam int T_MAX  = (T_DESINF_MS > T_MAX0) ? T_DESINF_MS : T_MAX0;
  localparam int TW     = bits_para(T_MAX);

  estado_t       est_q;
  estado_t       est_d;
  logic [TW-1:0] timer_q;
  logic          nivel;
  logic          pres_rise;
  logic          tick_ms;
  logic          key_inicio;
  logic          key_aborto;
  logic          key_rearme;
  logic          fin_entrada;
  logic          fin_desinf;
  logic          fin_salida;
  logic          fin_evt;

  antirrebote_sensor #(
    .CLK_HZ     (CLK_HZ),
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) u_antirrebote (
    .clk      (CLOCK_50),
    .rst_n    (rst_n),
    .sensor   (sensor),
    .nivel    (nivel),
    .pres_rise(pres_rise),
    .tick_ms  (tick_ms)
  );

  assign key_inicio = tecla_stb && (tecla == KEY_INICIO);
  assign key_aborto = tecla_stb && (tecla == KEY_ABORTO);
  assign key_rearme = tecla_stb && (tecla == KEY_REARME);

  // A phase of N ms ends in the cycle carrying the Nth tick after entry.
  assign fin_entrada = tick_ms && (timer_q == TW'(T_ENTRADA_MS - 1));
  assign fin_desinf  = tick_ms && (timer_q == TW'(T_DESINF_MS - 1));
  assign fin_salida  = tick_ms && (timer_q == TW'(T_SALIDA_MS - 1));

  // Priority inside a phase: abort key, then loss of presence, then timer expiry.
  always_comb begin
    est_d   = est_q;
    fin_evt = 1'b0;
    case (est_q)
      ST_IDLE: begin
        if (pres_rise || key_inicio) est_d = ST_ENTRADA;
      end
      ST_ENTRADA: begin
        if (key_aborto)       est_d = ST_ABORTO;
        else if (fin_entrada) est_d = ST_DESINF;
      end
      ST_DESINF: begin
        if (key_aborto || !nivel) est_d = ST_ABORTO;
        else if (fin_desinf)      est_d = ST_SALIDA;
      end
      ST_SALIDA: begin
        if (key_aborto) begin
          est_d = ST_ABORTO;
        end else if (fin_salida) begin
          est_d   = ST_IDLE;
          fin_evt = 1'b1;
        end
      end
      ST_ABORTO: begin
        if (key_rearme) est_d = ST_IDLE;
      end
      default: est_d = ST_IDLE;
    endcase
  end

  // The timer restarts on every state change; a tick landing on the entry cycle is not counted.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      est_q     <= ST_IDLE;
      timer_q   <= '0;
      fin_pulso <= 1'b0;
      ciclos    <= '0;
    end else begin
      est_q     <= est_d;
      timer_q   <= (est_d != est_q) ? '0 : timer_q + TW'(tick_ms);
      fin_pulso <= fin_evt;
      if (fin_evt && (ciclos != 8'hFF)) ciclos <= ciclos + 8'd1;
    end
  end

  // Actuator commands are registered from the current state.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= 3'd0;
      zumbador <= 1'b0;
      led      <= 1'b0;
      servo180 <= 1'b0;
      servo360 <= 1'b0;
    end else begin
      estado   <= est_q;
      zumbador <= (est_q == ST_ABORTO) ||
                  (((est_q == ST_ENTRADA) || (est_q == ST_SALIDA)) && (timer_q < TW'(BEEP_MS)));
      led      <= (est_q == ST_DESINF);
      servo360 <= (est_q == ST_DESINF);
      servo180 <= (est_q == ST_ENTRADA) || (est_q == ST_SALIDA);
    end
  end

endmodule

// File: tb/tb_secuenciador_camara.sv
// Scoreboard bench for secuenciador_camara with a 4-cycle ms tick.
// Expected output vectors and the cycle at which each one must appear are queued by the stimulus;
// a monitor pops one entry every time the DUT output vector changes.
module tb_secuenciador_camara;
  import camara_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n    = 1'b1;
  logic       sensor   = 1'b0;
  logic [5:0] tecla    = 6'd0;
  logic       tecla_stb = 1'b0;
  logic       zumbador, led, servo180, servo360, fin_pulso;
  logic [2:0] estado;
  logic [7:0] ciclos;

  secuenciador_camara #(
    .CLK_HZ(4000), .DEBOUNCE_MS(2), .T_ENTRADA_MS(5),
    .T_DESINF_MS(8), .T_SALIDA_MS(5), .BEEP_MS(2)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .sensor   (sensor),
    .tecla    (tecla),
    .tecla_stb(tecla_stb),
    .zumbador (zumbador),
    .led      (led),
    .servo180 (servo180),
    .servo360 (servo360),
    .estado   (estado),
    .ciclos   (ciclos),
    .fin_pulso(fin_pulso)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Posedges since reset release; ms ticks are consumed on posedges that are multiples of 4.
  int cyc = 0;
  always @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int          cyc;
    logic [14:0] vec;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [14:0] mk(input int e, input int z, input int l,
                                     input int a, input int b, input int c, input int f);
    logic [2:0] e3;
    logic [7:0] c8;
    e3 = e[2:0];
    c8 = c[7:0];
    return {e3, z[0], l[0], a[0], b[0], c8, f[0]};
  endfunction

  function automatic logic [14:0] obs();
    return {estado, zumbador, led, servo180, servo360, ciclos, fin_pulso};
  endfunction

  task automatic check(input string nombre, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d (0x%0h), expected %0d (0x%0h)",
               nombre, $time, act, act, req, req);
    end
  endtask

  task automatic push(input int c, input logic [14:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    q.push_back(e);
  endtask

  // Full cycle whose ENTRADA state is entered on posedge base+1.
  task automatic push_cycle(input int base, input int cp, input int cn);
    push(base + 2,  mk(1, 1, 0, 1, 0, cp, 0));
    push(base + 9,  mk(1, 0, 0, 1, 0, cp, 0));
    push(base + 21, mk(2, 0, 1, 0, 1, cp, 0));
    push(base + 53, mk(3, 1, 0, 1, 0, cp, 0));
    push(base + 61, mk(3, 0, 0, 1, 0, cp, 0));
    push(base + 72, mk(3, 0, 0, 1, 0, cn, 1));
    push(base + 73, mk(0, 0, 0, 0, 0, cn, 0));
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge CLOCK_50);
  endtask

  task automatic key(input logic [5:0] c);
    tecla     = c;
    tecla_stb = 1'b1;
    @(negedge CLOCK_50);
    tecla_stb = 1'b0;
    tecla     = 6'd0;
  endtask

  // Monitor: every change of the output vector must match the next queued entry.
  initial begin
    logic [14:0] prev;
    logic [14:0] cur;
    exp_t        e;
    prev = '0;
    forever begin
      @(negedge CLOCK_50);
      cur = obs();
      if (cur !== prev) begin
        if (q.size() == 0) begin
          check("unexpected_output_change", int'(cur), int'(prev));
        end else begin
          e = q.pop_front();
          check("output_vector", int'(cur), int'(e.vec));
          check("output_cycle", cyc, e.cyc);
        end
        prev = cur;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #1 rst_n = 1'b0;
    #2 check("reset_state", int'(obs()), 0);
    repeat (3) @(negedge CLOCK_50);
    rst_n = 1'b1;

    // 1: presence-started cycle, sensor held high throughout.
    wait_cyc(8);
    sensor = 1'b1;
    push_cycle(16, 0, 1);
    wait_cyc(92);
    sensor = 1'b0;

    // 2: 1-0-1 bounce restarts the debounce count; then abort and re-arm.
    wait_cyc(121);
    push(134, mk(1, 1, 0, 1, 0, 1, 0));
    sensor = 1'b1;
    wait_cyc(122);
    sensor = 1'b0;
    wait_cyc(123);
    sensor = 1'b1;
    wait_cyc(134);
    push(136, mk(4, 1, 0, 0, 0, 1, 0));
    key(KEY_ABORTO);
    wait_cyc(138);
    push(140, mk(0, 0, 0, 0, 0, 1, 0));
    key(KEY_REARME);
    wait_cyc(140);
    sensor = 1'b0;

    // 3: key start with no presence; DESINF aborts on sensor loss; other key ignored.
    wait_cyc(184);
    push(186, mk(1, 1, 0, 1, 0, 1, 0));
    push(193, mk(1, 0, 0, 1, 0, 1, 0));
    push(205, mk(2, 0, 1, 0, 1, 1, 0));
    push(206, mk(4, 1, 0, 0, 0, 1, 0));
    key(KEY_INICIO);
    wait_cyc(208);
    key(6'd5);
    wait_cyc(211);
    check("aborto_ignores_key5", int'(estado), 4);
    wait_cyc(212);
    push(214, mk(0, 0, 0, 0, 0, 1, 0));
    key(KEY_REARME);

    // 4: abort key on the same cycle as DESINF expiry wins over SALIDA.
    wait_cyc(220);
    sensor = 1'b1;
    push(230, mk(1, 1, 0, 1, 0, 1, 0));
    push(237, mk(1, 0, 0, 1, 0, 1, 0));
    push(249, mk(2, 0, 1, 0, 1, 1, 0));
    wait_cyc(279);
    push(281, mk(4, 1, 0, 0, 0, 1, 0));
    key(KEY_ABORTO);
    wait_cyc(284);
    key(6'd5);
    wait_cyc(290);
    check("aborto_holds", int'(estado), 4);
    wait_cyc(292);
    push(294, mk(0, 0, 0, 0, 0, 1, 0));
    key(KEY_REARME);

    // 5: asynchronous reset in the middle of DESINF.
    wait_cyc(300);
    push(302, mk(1, 1, 0, 1, 0, 1, 0));
    push(309, mk(1, 0, 0, 1, 0, 1, 0));
    push(321, mk(2, 0, 1, 0, 1, 1, 0));
    key(KEY_INICIO);
    wait_cyc(330);
    push(0, mk(0, 0, 0, 0, 0, 0, 0));
    #2;
    rst_n  = 1'b0;
    sensor = 1'b0;
    #1 check("async_reset_outputs", int'(obs()), 0);
    repeat (3) @(negedge CLOCK_50);
    rst_n = 1'b1;
    wait_cyc(40);
    check("after_reset_idle", int'(obs()), 0);

    // 6: 256 key-started cycles; presence raised during the first ENTRADA is not queued.
    k = 48;
    for (int i = 0; i < 256; i++) begin
      wait_cyc(k);
      push_cycle(k, (i > 255) ? 255 : i, (i + 1 > 255) ? 255 : i + 1);
      key(KEY_INICIO);
      if (i == 0) begin
        wait_cyc(k + 3);
        sensor = 1'b1;
      end
      k += 76;
    end
    wait_cyc(k);
    check("ciclos_saturated", int'(ciclos), 255);
    check("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
